// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types, widths and reset constant
// Provides: fetch_state_t (FETCH/HOLD/HALT), npc_sel_t (SEQ/BR/JMP/JR),
//           WORD_W, IMM_W, JADDR_W, RESET_PC_DEFAULT.
package cpu_pkg;

  localparam int WORD_W  = 32;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    JMP = 2'd2,
    JR  = 2'd3
  } npc_sel_t;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection and jr alignment check
// Inputs:  pc, branch_taken, branch_imm, jump, jaddress, jr, jr_target
// Outputs: next_pc (priority jr > jump > branch > sequential), misalign
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0]  pc,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   branch_imm,
  input  logic               jump,
  input  logic [JADDR_W-1:0] jaddress,
  input  logic               jr,
  input  logic [WORD_W-1:0]  jr_target,
  output logic [WORD_W-1:0]  next_pc,
  output logic               misalign
);

  npc_sel_t          sel;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] br_off;

  assign pc_plus4 = pc + 32'd4;

  // Word offset sign-extended and scaled to bytes.
  assign br_off = {{(WORD_W-IMM_W-2){branch_imm[IMM_W-1]}}, branch_imm, 2'b00};

  always_comb begin
    if (jr)                sel = JR;
    else if (jump)         sel = JMP;
    else if (branch_taken) sel = BR;
    else                   sel = SEQ;
  end

  always_comb begin
    case (sel)
      SEQ:     next_pc = pc_plus4;
      BR:      next_pc = pc_plus4 + br_off;
      JMP:     next_pc = {pc_plus4[WORD_W-1 -: 4], jaddress, 2'b00};
      JR:      next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

  assign misalign = jr && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage owning the PC and instruction register
// Memory side: imem_req/imem_addr out, imem_ready/imem_rdata in.
// Decode side: instr_out/instr_valid/pc_out/pc_plus4_out out, stall in.
// Redirect:    branch_taken/branch_imm, jump/jaddress, jr/jr_target in.
// Status:      fetch_fault (sticky, misaligned jr target; cleared by reset).
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [WORD_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [WORD_W-1:0]  imem_rdata,
  output logic [WORD_W-1:0]  instr_out,
  output logic               instr_valid,
  input  logic               stall,
  output logic [WORD_W-1:0]  pc_out,
  output logic [WORD_W-1:0]  pc_plus4_out,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   branch_imm,
  input  logic               jump,
  input  logic [JADDR_W-1:0] jaddress,
  input  logic               jr,
  input  logic [WORD_W-1:0]  jr_target,
  output logic               fetch_fault
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] next_pc;
  logic              misalign;

  next_pc_calc u_next_pc_calc (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jaddress     (jaddress),
    .jr           (jr),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  // Gated by reset so the request drops the moment reset rises and returns
  // in the first cycle after it falls; a ready seen meanwhile is ignored.
  assign imem_req     = (state == FETCH) && !reset;
  assign imem_addr    = pc;
  assign pc_out       = pc;
  assign pc_plus4_out = pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            instr_out   <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // Redirect inputs matter only on the consuming edge.
          if (!stall) begin
            instr_valid <= 1'b0;
            if (misalign) begin
              fetch_fault <= 1'b1;
              state       <= HALT;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jaddress;
  logic        jr;
  logic [31:0] jr_target;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jaddress     (jaddress),
    .jr           (jr),
    .jr_target    (jr_target),
    .fetch_fault  (fetch_fault)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] mpc;

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic [15:0] imm;
    logic        j;
    logic [25:0] ja;
    logic        jrr;
    logic [31:0] jrt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = '0;
    jump         = 1'b0;
    jaddress     = '0;
    jr           = 1'b0;
    jr_target    = '0;
  endtask

  // Architectural next-PC rule written as plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br,
                                           input logic [15:0] imm, input logic j,
                                           input logic [25:0] ja, input logic jrr,
                                           input logic [31:0] jrt);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    if (jrr) return jrt;
    if (j) return (seq & 32'hF000_0000) | (32'(ja) * 32'd4);
    if (br) begin
      off = int'($signed(imm)) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  // One memory transaction at address exp_pc with 'waits' not-ready cycles.
  task automatic fetch(input int waits, input logic [31:0] data, input logic [31:0] exp_pc);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      imem_ready = 1'b0;
      step();
    end
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ready = 1'b1;
    imem_rdata = data;
    step();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", instr_out, data);
    chk("hold_pc", pc_out, exp_pc);
    chk("hold_pc4", pc_plus4_out, exp_pc + 32'd4);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic goto_pc(input logic [31:0] target);
    fetch(0, $urandom, mpc);
    jr        = 1'b1;
    jr_target = target;
    step();
    clear_ctl();
    mpc = target;
  endtask

  initial begin
    logic [31:0] data;
    logic [31:0] exp_n;
    logic        r_br, r_j, r_jr;
    logic [15:0] r_imm;
    logic [25:0] r_ja;
    logic [31:0] r_jrt;

    vecs[0] = '{32'h0000_0040, 1'b1, 16'hFFFE, 1'b0, 26'h0,       1'b0, 32'h0,   32'h0000_003C};
    vecs[1] = '{32'h0000_0040, 1'b1, 16'h0003, 1'b0, 26'h0,       1'b0, 32'h0,   32'h0000_0050};
    vecs[2] = '{32'h2000_0010, 1'b1, 16'h0007, 1'b1, 26'h10,      1'b1, 32'h100, 32'h0000_0100};
    vecs[3] = '{32'h2000_0010, 1'b1, 16'h0007, 1'b1, 26'h10,      1'b0, 32'h100, 32'h2000_0040};
    vecs[4] = '{32'hFFFF_FFFC, 1'b0, 16'h0000, 1'b0, 26'h0,       1'b0, 32'h0,   32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFC, 1'b1, 16'h0001, 1'b0, 26'h0,       1'b0, 32'h0,   32'h0000_0004};
    vecs[6] = '{32'hFFFF_FFFC, 1'b0, 16'h0000, 1'b1, 26'h3FFFFFF, 1'b0, 32'h0,   32'h0FFF_FFFC};

    reset      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    clear_ctl();
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);

    reset = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);
    mpc = 32'd0;

    // Back-to-back sequential fetch with immediate ready.
    for (int k = 0; k < 3; k++) begin
      data = 32'hA500_0000 + 32'(k);
      chk("seq_addr", imem_addr, 32'(k * 4));
      chk("seq_valid_lo", {31'd0, instr_valid}, 32'd0);
      imem_ready = 1'b1;
      imem_rdata = data;
      step();
      chk("seq_valid_hi", {31'd0, instr_valid}, 32'd1);
      chk("seq_instr", instr_out, data);
      step();
    end
    imem_ready = 1'b0;
    mpc = 32'd12;

    // Table of redirect vectors.
    for (int v = 0; v < 7; v++) begin
      goto_pc(vecs[v].pc);
      fetch(0, $urandom, vecs[v].pc);
      branch_taken = vecs[v].br;
      branch_imm   = vecs[v].imm;
      jump         = vecs[v].j;
      jaddress     = vecs[v].ja;
      jr           = vecs[v].jrr;
      jr_target    = vecs[v].jrt;
      step();
      clear_ctl();
      chk($sformatf("vec%0d_addr", v), imem_addr, vecs[v].exp);
      chk($sformatf("vec%0d_req", v), {31'd0, imem_req}, 32'd1);
      mpc = vecs[v].exp;
    end

    // Stall for 5 cycles while branch_taken toggles; only the consuming edge counts.
    goto_pc(32'h0000_1000);
    fetch(1, 32'hCAFE_F00D, mpc);
    for (int i = 0; i < 5; i++) begin
      stall        = 1'b1;
      branch_taken = i[0] ? 1'b0 : 1'b1;
      branch_imm   = 16'h0010;
      step();
      chk("stall_instr", instr_out, 32'hCAFE_F00D);
      chk("stall_pc", pc_out, 32'h0000_1000);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    clear_ctl();
    step();
    chk("stall_release_addr", imem_addr, 32'h0000_1004);
    mpc = 32'h0000_1004;

    // Randomized instruction stream against the reference rule.
    for (int n = 0; n < 150; n++) begin
      fetch(int'($urandom_range(0, 3)), $urandom, mpc);
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        stall        = 1'b1;
        branch_taken = 1'($urandom);
        jump         = 1'($urandom);
        jr           = 1'($urandom);
        jr_target    = $urandom;
        step();
        chk("rnd_stall_pc", pc_out, mpc);
        chk("rnd_stall_valid", {31'd0, instr_valid}, 32'd1);
      end
      r_br  = 1'($urandom);
      r_j   = ($urandom_range(0, 3) == 0);
      r_jr  = ($urandom_range(0, 5) == 0);
      r_imm = 16'($urandom);
      r_ja  = 26'($urandom);
      r_jrt = $urandom & 32'hFFFF_FFFC;
      stall        = 1'b0;
      branch_taken = r_br;
      branch_imm   = r_imm;
      jump         = r_j;
      jaddress     = r_ja;
      jr           = r_jr;
      jr_target    = r_jrt;
      exp_n = ref_next(mpc, r_br, r_imm, r_j, r_ja, r_jr, r_jrt);
      step();
      clear_ctl();
      chk("rnd_consume_valid", {31'd0, instr_valid}, 32'd0);
      chk("rnd_next_addr", imem_addr, exp_n);
      mpc = exp_n;
    end

    // Reset arriving in the second waiting cycle of a slow access.
    goto_pc(32'h0000_0080);
    imem_ready = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_instr", instr_out, 32'd0);
    reset = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("midrst_addr", imem_addr, 32'd0);
    chk("midrst_req_back", {31'd0, imem_req}, 32'd1);
    step();
    chk("midrst_still_fetch", {31'd0, instr_valid}, 32'd0);
    mpc = 32'd0;

    // Misaligned jr halts the stage until reset.
    goto_pc(32'h0000_0200);
    fetch(0, $urandom, mpc);
    jr        = 1'b1;
    jr_target = 32'h0000_0102;
    step();
    clear_ctl();
    chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_pc", pc_out, 32'h0000_0200);
    for (int i = 0; i < 12; i++) begin
      imem_ready = 1'b1;
      step();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_fault_sticky", {31'd0, fetch_fault}, 32'd1);
    end
    imem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("halt_rst_fault", {31'd0, fetch_fault}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("halt_rst_req", {31'd0, imem_req}, 32'd1);
    chk("halt_rst_addr", imem_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
